// File: rtl/change_dispenser.sv
// Pays a change amount out as physical notes, greedy largest-note-first against a
// per-denomination inventory; any unpayable residual is reported as shortfall.
module change_dispenser #(
  parameter int unsigned AMT_W    = 8,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned INIT_CNT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             change_valid,
  input  logic [AMT_W-1:0] change_amount,
  input  logic             refill,
  input  logic             eject_ready,
  output logic             eject_valid,
  output logic [1:0]       eject_denom,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] shortfall,
  output logic [3:0]       empty
);

  typedef enum logic [1:0] {StIdle, StSelect, StEject, StDone} state_e;

  state_e           state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [AMT_W-1:0] shortfall_q, shortfall_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic             eject_valid_q, eject_valid_d;
  logic [1:0]       eject_denom_q, eject_denom_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             settle_q, settle_d;
  logic             sel_found;
  logic [1:0]       sel_code;

  function automatic logic [AMT_W-1:0] denom_val(input logic [1:0] code);
    logic [AMT_W-1:0] v;
    unique case (code)
      2'd0:    v = AMT_W'(5);
      2'd1:    v = AMT_W'(10);
      2'd2:    v = AMT_W'(20);
      default: v = AMT_W'(50);
    endcase
    return v;
  endfunction

  // Ascending scan: the last qualifying code is the largest payable note.
  always_comb begin
    sel_found = 1'b0;
    sel_code  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (cnt_q[i] != '0 && denom_val(2'(i)) <= remaining_q) begin
        sel_found = 1'b1;
        sel_code  = 2'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      empty[i] = (cnt_q[i] == '0);
    end
  end

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    shortfall_d   = shortfall_q;
    cnt_d         = cnt_q;
    eject_valid_d = eject_valid_q;
    eject_denom_d = eject_denom_q;
    done_d        = 1'b0;
    settle_d      = settle_q;

    unique case (state_q)
      StIdle: begin
        if (refill) begin
          for (int i = 0; i < 4; i++) begin
            cnt_d[i] = CNT_W'(INIT_CNT);
          end
        end
        if (change_valid) begin
          remaining_d = change_amount;
          settle_d    = 1'b1;
          state_d     = StSelect;
        end
      end
      StSelect: begin
        // The first pass after accepting a request only aligns the payout to its
        // two-edge start latency; later passes select immediately.
        if (settle_q) begin
          settle_d = 1'b0;
        end else if (sel_found) begin
          eject_valid_d = 1'b1;
          eject_denom_d = sel_code;
          state_d       = StEject;
        end else begin
          shortfall_d = remaining_q;
          done_d      = 1'b1;
          state_d     = StDone;
        end
      end
      StEject: begin
        if (eject_ready) begin
          remaining_d          = remaining_q - denom_val(eject_denom_q);
          cnt_d[eject_denom_q] = cnt_q[eject_denom_q] - CNT_W'(1);
          eject_valid_d        = 1'b0;
          state_d              = StSelect;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      remaining_q   <= '0;
      shortfall_q   <= '0;
      eject_valid_q <= 1'b0;
      eject_denom_q <= 2'd0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      settle_q      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= CNT_W'(INIT_CNT);
      end
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      shortfall_q   <= shortfall_d;
      eject_valid_q <= eject_valid_d;
      eject_denom_q <= eject_denom_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      settle_q      <= settle_d;
      cnt_q         <= cnt_d;
    end
  end

  assign eject_valid = eject_valid_q;
  assign eject_denom = eject_denom_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign shortfall   = shortfall_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against a greedy note-counting reference model.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       change_valid = 1'b0;
  logic [7:0] change_amount = '0;
  logic       refill = 1'b0;
  logic       eject_ready = 1'b0;
  logic       eject_valid;
  logic [1:0] eject_denom;
  logic       busy;
  logic       done;
  logic [7:0] shortfall;
  logic [3:0] empty;

  // Second instance with a single note per denomination.
  logic       cv_b = 1'b0;
  logic [7:0] amt_b = '0;
  logic       refill_b = 1'b0;
  logic       ready_b = 1'b1;
  logic       ev_b;
  logic [1:0] denom_b;
  logic       busy_b;
  logic       done_b;
  logic [7:0] sf_b;
  logic [3:0] empty_b;

  int n_checks = 0;
  int n_err    = 0;

  int m_cnt [4];
  int vals  [4] = '{5, 10, 20, 50};
  int exp_q [$];
  int exp_sf;

  change_dispenser #(.AMT_W(8), .CNT_W(4), .INIT_CNT(8)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .change_valid (change_valid),
    .change_amount(change_amount),
    .refill       (refill),
    .eject_ready  (eject_ready),
    .eject_valid  (eject_valid),
    .eject_denom  (eject_denom),
    .busy         (busy),
    .done         (done),
    .shortfall    (shortfall),
    .empty        (empty)
  );

  change_dispenser #(.AMT_W(8), .CNT_W(4), .INIT_CNT(1)) u_dut_one (
    .clk          (clk),
    .rst          (rst),
    .change_valid (cv_b),
    .change_amount(amt_b),
    .refill       (refill_b),
    .eject_ready  (ready_b),
    .eject_valid  (ev_b),
    .eject_denom  (denom_b),
    .busy         (busy_b),
    .done         (done_b),
    .shortfall    (sf_b),
    .empty        (empty_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_refill();
    for (int i = 0; i < 4; i++) m_cnt[i] = 8;
  endtask

  function automatic logic [3:0] model_empty();
    logic [3:0] e;
    for (int i = 0; i < 4; i++) e[i] = (m_cnt[i] == 0);
    return e;
  endfunction

  // Greedy payout over the model inventory; fills exp_q/exp_sf and consumes notes.
  task automatic model_pay(input int amt);
    int rem;
    int best;
    rem = amt;
    exp_q.delete();
    forever begin
      best = -1;
      for (int i = 3; i >= 0; i--) begin
        if (best < 0 && m_cnt[i] > 0 && vals[i] <= rem) best = i;
      end
      if (best < 0) break;
      exp_q.push_back(best);
      rem -= vals[best];
      m_cnt[best]--;
    end
    exp_sf = rem;
  endtask

  function automatic int pick_stall(input int stall_fix);
    return (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 3));
  endfunction

  task automatic do_payout(input int amt, input bit with_refill, input int stall_fix,
                           input bit poke_busy, input bit refill_busy);
    int  idx;
    int  cyc;
    int  first_evt;
    int  stall;
    bit  got_done;
    if (with_refill) model_refill();
    model_pay(amt);
    @(negedge clk);
    change_valid  = 1'b1;
    change_amount = amt[7:0];
    refill        = with_refill;
    @(negedge clk);
    change_valid = 1'b0;
    refill       = 1'b0;
    chk("busy_after_accept", busy, 1);
    idx = 0; cyc = 0; first_evt = -1; got_done = 0;
    stall = pick_stall(stall_fix);
    while (!got_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      change_valid = 1'b0;
      refill       = 1'b0;
      if (first_evt < 0 && (eject_valid || done)) begin
        first_evt = cyc;
        chk("start_latency", cyc, 2);
      end
      if (poke_busy && cyc == 3) begin
        change_valid  = 1'b1;
        change_amount = 8'd50;
      end
      if (refill_busy && cyc == 3) refill = 1'b1;
      if (done) begin
        got_done = 1;
        chk("notes_paid", idx, exp_q.size());
        chk("shortfall", shortfall, exp_sf);
        chk("valid_at_done", eject_valid, 0);
      end else if (eject_valid) begin
        if (idx >= exp_q.size()) chk("extra_eject", eject_valid, 0);
        else chk("denom", eject_denom, exp_q[idx]);
        chk("busy_during_eject", busy, 1);
        if (stall > 0) begin
          eject_ready = 1'b0;
          stall--;
        end else begin
          eject_ready = 1'b1;
          idx++;
          stall = pick_stall(stall_fix);
        end
      end else begin
        eject_ready = 1'($urandom_range(0, 1));
      end
    end
    if (!got_done) chk("done_timeout", done, 1);
    eject_ready = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_back_idle", busy, 0);
    chk("empty", empty, model_empty());
  endtask

  initial begin
    int got_b [$];
    int r;
    bit seen;

    model_refill();
    repeat (3) @(negedge clk);
    chk("rst_valid", eject_valid, 0);
    chk("rst_denom", eject_denom, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_shortfall", shortfall, 0);
    chk("rst_empty", empty, 0);
    rst = 1'b0;

    // One-of-each inventory: 90 -> 50,20,10,5 with 5 left unpaid.
    @(negedge clk);
    cv_b = 1'b1; amt_b = 8'd90;
    @(negedge clk);
    cv_b = 1'b0;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (ev_b) got_b.push_back(int'(denom_b));
      if (done_b) begin
        seen = 1;
        chk("one_shortfall", sf_b, 5);
        chk("one_empty", empty_b, 4'b1111);
      end
    end
    if (!seen) chk("one_done_timeout", done_b, 1);
    chk("one_count", got_b.size(), 4);
    for (int i = 0; i < got_b.size() && i < 4; i++) chk("one_denom", got_b[i], 3 - i);

    do_payout(35, 0, 0, 0, 0);
    do_payout(20, 0, 5, 0, 0);
    do_payout(7, 0, -1, 0, 0);
    do_payout(0, 0, -1, 0, 0);
    do_payout(75, 0, -1, 1, 0);

    // Asynchronous reset while a note is presented.
    @(negedge clk);
    change_valid = 1'b1; change_amount = 8'd50;
    @(negedge clk);
    change_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (eject_valid) seen = 1;
    end
    if (!seen) chk("mid_valid", eject_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", eject_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_shortfall", shortfall, 0);
    chk("mid_rst_empty", empty, 0);
    @(negedge clk);
    rst = 1'b0;
    model_refill();

    // Drain the 5s, then refill attempts while busy and while idle.
    for (int i = 0; i < 8; i++) do_payout(5, 0, -1, 0, 0);
    do_payout(5, 0, -1, 0, 0);
    do_payout(60, 0, -1, 0, 1);
    @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    model_refill();
    chk("refill_idle_empty", empty, 0);
    do_payout(5, 1, -1, 0, 0);

    for (int t = 0; t < 40; t++) begin
      r = int'($urandom_range(0, 5));
      if (r == 1) begin
        @(negedge clk);
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        model_refill();
      end
      do_payout(int'($urandom_range(0, 255)), r == 0, -1, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
